// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry, FSM state encodings and bit-period helper.
// Used by both the transmitter and the receiver.
package uart_pkg;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_LOAD,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_e;

  typedef enum logic {
    WR_IDLE,
    WR_DONE
  } wr_state_e;

  // The prescaler ticks at 8x the baud rate, so one bit lasts eight prescale periods.
  function automatic int bitPeriod(input int prescale);
    return prescale * 8;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous FIFO with registered read data and registered occupancy count.
// Push is ignored when full, pop is ignored when empty.
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                         i_clock,
  input  logic                         i_reset,
  input  logic                         i_push,
  input  logic [WIDTH-1:0]             i_wdata,
  input  logic                         i_pop,
  output logic [WIDTH-1:0]             o_rdata,
  output logic                         o_empty,
  output logic                         o_full,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;
  logic [AW-1:0]    wrPtr_q;
  logic [AW-1:0]    rdPtr_q;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic             doPush;
  logic             doPop;

  assign o_full  = (count_q == CW'(DEPTH));
  assign o_empty = (count_q == '0);
  assign doPush  = i_push && !o_full;
  assign doPop   = i_pop && !o_empty;

  always_comb begin
    count_d = count_q;
    case ({doPush, doPop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage carries no reset; only pointers and count define what is valid.
  always_ff @(posedge i_clock) begin
    if (doPush) begin
      mem_q[wrPtr_q] <= i_wdata;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
      rdata_q <= '0;
    end else begin
      count_q <= count_d;
      if (doPush) begin
        wrPtr_q <= wrPtr_q + AW'(1);
      end
      if (doPop) begin
        rdata_q <= mem_q[rdPtr_q];
        rdPtr_q <= rdPtr_q + AW'(1);
      end
    end
  end

  assign o_rdata = rdata_q;
  assign o_count = count_q;

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: bus write handshake into a byte FIFO, drained LSB first
// onto a registered serial line by the transmit FSM.
module uart_tx
  import uart_pkg::*;
#(
  parameter int PRESCALE = 50000000 / (9600 * 8),
  parameter int DEPTH    = 4
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_request,
  input  logic [31:0] i_wdata,
  output logic        o_ready,
  output logic        o_busy,
  output logic        UART_TX
);

  localparam int T      = bitPeriod(PRESCALE);
  localparam int STOP_T = T * STOP_BITS;
  localparam int PW     = $clog2(STOP_T);
  localparam logic [PW-1:0] BIT_LOAD  = PW'(T - 1);
  localparam logic [PW-1:0] STOP_LOAD = PW'(STOP_T - 1);
  localparam logic [3:0]    BITS_LOAD = 4'(DATA_BITS);

  wr_state_e                    wrState_q;
  tx_state_e                    txState_q;
  logic [DATA_BITS-1:0]         shift_q;
  logic [PW-1:0]                prescale_q;
  logic [3:0]                   bitCount_q;
  logic                         txLine_q;

  logic                         fifoPush;
  logic                         fifoPop;
  logic [DATA_BITS-1:0]         fifoRdata;
  logic                         fifoEmpty;
  logic                         fifoFull;
  logic [$clog2(DEPTH+1)-1:0]   unusedFifoCount;
  logic                         unusedWdata;

  assign unusedWdata = ^i_wdata[31:8];

  assign fifoPush = (wrState_q == WR_IDLE) && i_request && !fifoFull;
  assign fifoPop  = (txState_q == TX_IDLE) && !fifoEmpty;
  assign o_ready  = (wrState_q == WR_DONE) && i_request;
  assign o_busy   = !fifoEmpty || (txState_q != TX_IDLE);
  assign UART_TX  = txLine_q;

  uart_tx_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_push  (fifoPush),
    .i_wdata (i_wdata[DATA_BITS-1:0]),
    .i_pop   (fifoPop),
    .o_rdata (fifoRdata),
    .o_empty (fifoEmpty),
    .o_full  (fifoFull),
    .o_count (unusedFifoCount)
  );

  // One push per request: DONE waits for the strobe to drop before re-arming.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      wrState_q <= WR_IDLE;
    end else begin
      case (wrState_q)
        WR_IDLE: if (fifoPush) wrState_q <= WR_DONE;
        WR_DONE: if (!i_request) wrState_q <= WR_IDLE;
        default: wrState_q <= WR_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      txState_q  <= TX_IDLE;
      txLine_q   <= 1'b1;
      shift_q    <= '0;
      prescale_q <= '0;
      bitCount_q <= '0;
    end else begin
      case (txState_q)
        TX_IDLE: begin
          if (!fifoEmpty) txState_q <= TX_LOAD;
        end
        // FIFO read data becomes valid the cycle after the pop issued in IDLE.
        TX_LOAD: begin
          shift_q    <= fifoRdata;
          txLine_q   <= 1'b0;
          prescale_q <= BIT_LOAD;
          txState_q  <= TX_START;
        end
        TX_START: begin
          if (prescale_q == '0) begin
            txLine_q   <= shift_q[0];
            shift_q    <= shift_q >> 1;
            bitCount_q <= BITS_LOAD;
            prescale_q <= BIT_LOAD;
            txState_q  <= TX_DATA;
          end else begin
            prescale_q <= prescale_q - PW'(1);
          end
        end
        TX_DATA: begin
          if (prescale_q == '0) begin
            if (bitCount_q == 4'd1) begin
              txLine_q   <= 1'b1;
              bitCount_q <= '0;
              prescale_q <= STOP_LOAD;
              txState_q  <= TX_STOP;
            end else begin
              txLine_q   <= shift_q[0];
              shift_q    <= shift_q >> 1;
              bitCount_q <= bitCount_q - 4'd1;
              prescale_q <= BIT_LOAD;
            end
          end else begin
            prescale_q <= prescale_q - PW'(1);
          end
        end
        TX_STOP: begin
          if (prescale_q == '0) begin
            txState_q <= TX_IDLE;
          end else begin
            prescale_q <= prescale_q - PW'(1);
          end
        end
        default: txState_q <= TX_IDLE;
      endcase
    end
  end

endmodule
